uart_rx_ctrl: RTL

//  Frame-sequencing FSM for the UART receiver. Counts oversampling edges and bits, and

---
 rtl/uart_rx_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: frame-sequencing FSM for the UART receiver.
// Counts oversampling edges and data bits, pulses the sampler, deserializer and
// start/parity/stop checker enables, and folds checker results into a single
// result pulse per frame (data_valid, or par_err_o/frm_err_o).
// Optional feature macro: RX_ERR_CNT_EN adds a saturating 8-bit error counter
// output err_cnt (start aborts plus frames ending in an error).
//
// Checker timing contract: each *_chk_en pulse is high in the cycle where
// edge_cnt==Prescale-2; the checker registers its verdict, so the verdict is
// valid in the following cycle (edge_cnt==Prescale-1), which is exactly the
// wrap cycle on which this FSM takes its state decision.
module uart_rx_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_IN,
   input  logic [5:0] Prescale,
   input  logic       PAR_EN,
   input  logic       PAR_TYP,
   input  logic       strt_glitch,
   input  logic       par_err,
   input  logic       stp_err,
   output logic       dat_samp_en,
   output logic       strt_chk_en,
   output logic       deser_en,
   output logic       par_chk_en,
   output logic       stp_chk_en,
   output logic       par_typ_o,
   output logic       data_valid,
   output logic       par_err_o,
   output logic       frm_err_o,
   output logic       busy
`ifdef RX_ERR_CNT_EN
   ,
   output logic [7:0] err_cnt
`endif
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state, state_nx;
   logic [5:0]    edge_cnt, edge_nx;
   logic [BW-1:0] bit_cnt, bit_nx;
   logic [5:0]    pre_q, pre_nx, pre_in;
   logic          par_en_q, par_en_nx;
   logic          par_typ_nx;
   logic          par_flag, par_flag_nx;
   logic          data_valid_nx, par_err_nx, frm_err_nx;
   logic          wrap, chk_pt;

   // Prescale below 4 would leave no room for the enable-then-decide pair.
   assign pre_in = (Prescale < 6'd4) ? 6'd4 : Prescale;
   // Decision cycle of the current bit period (uses the frame-latched ratio).
   assign wrap   = (edge_cnt == pre_q - 6'd1);
   // Enable cycle of the coming bit period, one cycle ahead of the decision.
   assign chk_pt = (edge_nx == pre_nx - 6'd2);

   // Next-state, counter and result logic; state changes only on the wrap cycle.
   always_comb begin
      state_nx      = state;
      edge_nx       = edge_cnt;
      bit_nx        = bit_cnt;
      pre_nx        = pre_q;
      par_en_nx     = par_en_q;
      par_typ_nx    = par_typ_o;
      par_flag_nx   = par_flag;
      data_valid_nx = 1'b0;
      par_err_nx    = 1'b0;
      frm_err_nx    = 1'b0;
      if (state == IDLE) begin
         edge_nx = '0;
         bit_nx  = '0;
         if (!RX_IN) begin
            state_nx    = START;
            pre_nx      = pre_in;
            par_en_nx   = PAR_EN;
            par_typ_nx  = PAR_TYP;
            par_flag_nx = 1'b0;
         end
      end else begin
         edge_nx = wrap ? 6'd0 : edge_cnt + 6'd1;
         if (wrap) begin
            case (state)
               START:  state_nx = strt_glitch ? IDLE : DATA;
               DATA: begin
                  if (bit_cnt == BIT_LAST) begin
                     bit_nx   = '0;
                     state_nx = par_en_q ? PARITY : STOP;
                  end else begin
                     bit_nx = bit_cnt + BW'(1);
                  end
               end
               PARITY: begin
                  par_flag_nx = par_err;
                  state_nx    = STOP;
               end
               STOP: begin
                  state_nx      = IDLE;
                  data_valid_nx = !stp_err && !par_flag;
                  par_err_nx    = par_flag;
                  frm_err_nx    = stp_err;
               end
               default: state_nx = IDLE;
            endcase
         end
      end
   end

   // State, counters, latched frame settings and all registered outputs.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state       <= IDLE;
         edge_cnt    <= '0;
         bit_cnt     <= '0;
         pre_q       <= '0;
         par_en_q    <= 1'b0;
         par_flag    <= 1'b0;
         par_typ_o   <= 1'b0;
         dat_samp_en <= 1'b0;
         busy        <= 1'b0;
         strt_chk_en <= 1'b0;
         deser_en    <= 1'b0;
         par_chk_en  <= 1'b0;
         stp_chk_en  <= 1'b0;
         data_valid  <= 1'b0;
         par_err_o   <= 1'b0;
         frm_err_o   <= 1'b0;
      end else begin
         state       <= state_nx;
         edge_cnt    <= edge_nx;
         bit_cnt     <= bit_nx;
         pre_q       <= pre_nx;
         par_en_q    <= par_en_nx;
         par_flag    <= par_flag_nx;
         par_typ_o   <= par_typ_nx;
         dat_samp_en <= (state_nx != IDLE);
         busy        <= (state_nx != IDLE);
         strt_chk_en <= (state_nx == START)  && chk_pt;
         deser_en    <= (state_nx == DATA)   && chk_pt;
         par_chk_en  <= (state_nx == PARITY) && chk_pt;
         stp_chk_en  <= (state_nx == STOP)   && chk_pt;
         data_valid  <= data_valid_nx;
         par_err_o   <= par_err_nx;
         frm_err_o   <= frm_err_nx;
      end
   end

`ifdef RX_ERR_CNT_EN
   logic err_inc;
   assign err_inc = wrap && (((state == START) && strt_glitch) ||
                             ((state == STOP) && (stp_err || par_flag)));

   // Saturating count of start aborts and frames ending with an error.
   always_ff @(posedge CLK) begin
      if (!RST)
         err_cnt <= '0;
      else if (err_inc && (err_cnt != 8'hFF))
         err_cnt <= err_cnt + 8'd1;
   end
`endif

endmodule
